// File: rtl/ss_pkg.sv
// Shared seven-segment constants (abcdefg, bit6=a .. bit0=g) and capture FSM encoding.
// Used by both the segment encoder and the scan capture block.
package ss_pkg;

  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  localparam logic [3:0] CODE_INVALID = 4'hF;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_SETTLE = 2'd1;
  localparam state_t ST_HOLD   = 2'd2;

endpackage

// File: rtl/ss_scan_capture_if.sv
// Multiplexed seven-segment bus in, per-digit decoded registers and update strobes out.
// The master drives segments/enables; the slave (capture block) drives the results.
interface ss_scan_capture_if #(
  parameter int NUM_DIGITS = 4
);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [6:0]              seg;
  logic [NUM_DIGITS-1:0]   dig_en;
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   invalid;
  logic                    upd_valid;
  logic [IDX_W-1:0]        upd_idx;
  logic                    frame_done;

  modport master (
    output seg, dig_en,
    input  value, invalid, upd_valid, upd_idx, frame_done
  );

  modport slave (
    input  seg, dig_en,
    output value, invalid, upd_valid, upd_idx, frame_done
  );

endinterface

// File: rtl/ss_pattern_decode.sv
// Combinational seven-segment to BCD decoder; zero latency, no flow control.
// Anything outside the ten digit glyphs (blank included) maps to CODE_INVALID.
module ss_pattern_decode
  import ss_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] code,
  output logic       invalid
);

  always_comb begin
    code    = CODE_INVALID;
    invalid = 1'b1;
    case (seg)
      SEG_0:   begin code = 4'd0; invalid = 1'b0; end
      SEG_1:   begin code = 4'd1; invalid = 1'b0; end
      SEG_2:   begin code = 4'd2; invalid = 1'b0; end
      SEG_3:   begin code = 4'd3; invalid = 1'b0; end
      SEG_4:   begin code = 4'd4; invalid = 1'b0; end
      SEG_5:   begin code = 4'd5; invalid = 1'b0; end
      SEG_6:   begin code = 4'd6; invalid = 1'b0; end
      SEG_7:   begin code = 4'd7; invalid = 1'b0; end
      SEG_8:   begin code = 4'd8; invalid = 1'b0; end
      SEG_9:   begin code = 4'd9; invalid = 1'b0; end
      default: begin code = CODE_INVALID; invalid = 1'b1; end
    endcase
  end

endmodule

// File: rtl/ss_scan_capture.sv
// Captures one decoded digit per dwell once seg/dig_en have been stable STABLE_CYCLES samples.
// Update appears STABLE_CYCLES+1 edges after the dwell starts; no backpressure, outputs are strobes.
module ss_scan_capture
  import ss_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input logic              clk,
  input logic              rst_n,
  ss_scan_capture_if.slave bus
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(STABLE_CYCLES);

  logic [6:0]              seg_q, ref_seg, ref_seg_n;
  logic [NUM_DIGITS-1:0]   en_q, ref_en, ref_en_n, mask, mask_set;
  state_t                  state, state_n;
  logic [CNT_W-1:0]        cnt, cnt_n;
  logic                    do_cap, en_is_onehot;
  logic [IDX_W-1:0]        en_idx;
  logic [3:0]              dec_code;
  logic                    dec_inv;
  logic [4*NUM_DIGITS-1:0] value_r;
  logic [NUM_DIGITS-1:0]   invalid_r;
  logic                    upd_valid_r, frame_done_r;
  logic [IDX_W-1:0]        upd_idx_r;

  ss_pattern_decode u_decode (
    .seg     (seg_q),
    .code    (dec_code),
    .invalid (dec_inv)
  );

  assign en_is_onehot = $onehot(en_q);
  // On a capture en_q is the one-hot digit bit, so it doubles as the mask update.
  assign mask_set     = mask | en_q;

  always_comb begin
    en_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (en_q[i]) en_idx = IDX_W'(i);
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    ref_seg_n = ref_seg;
    ref_en_n  = ref_en;
    do_cap    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (en_is_onehot) begin
          ref_seg_n = seg_q;
          ref_en_n  = en_q;
          if (STABLE_CYCLES == 1) begin
            do_cap  = 1'b1;
            cnt_n   = CNT_SAT;
            state_n = ST_HOLD;
          end else begin
            cnt_n   = CNT_ONE;
            state_n = ST_SETTLE;
          end
        end
      end
      ST_SETTLE: begin
        if (!en_is_onehot) begin
          cnt_n   = '0;
          state_n = ST_IDLE;
        end else if (seg_q == ref_seg && en_q == ref_en) begin
          if (cnt >= CNT_LAST) begin
            cnt_n   = CNT_SAT;
            do_cap  = 1'b1;
            state_n = ST_HOLD;
          end else begin
            cnt_n = cnt + CNT_ONE;
          end
        end else begin
          ref_seg_n = seg_q;
          ref_en_n  = en_q;
          cnt_n     = CNT_ONE;
        end
      end
      ST_HOLD: begin
        // Segment changes within the same dwell are ignored: one capture per dwell.
        if (en_q != ref_en) begin
          cnt_n   = '0;
          state_n = ST_IDLE;
        end
      end
      default: begin
        cnt_n   = '0;
        state_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q        <= '0;
      en_q         <= '0;
      state        <= ST_IDLE;
      cnt          <= '0;
      ref_seg      <= '0;
      ref_en       <= '0;
      mask         <= '0;
      value_r      <= {NUM_DIGITS{CODE_INVALID}};
      invalid_r    <= '1;
      upd_valid_r  <= 1'b0;
      upd_idx_r    <= '0;
      frame_done_r <= 1'b0;
    end else begin
      seg_q        <= bus.seg;
      en_q         <= bus.dig_en;
      state        <= state_n;
      cnt          <= cnt_n;
      ref_seg      <= ref_seg_n;
      ref_en       <= ref_en_n;
      upd_valid_r  <= do_cap;
      frame_done_r <= do_cap && (&mask_set);
      if (do_cap) begin
        upd_idx_r <= en_idx;
        mask      <= (&mask_set) ? '0 : mask_set;
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (en_q[i]) begin
            value_r[4*i +: 4] <= dec_code;
            invalid_r[i]      <= dec_inv;
          end
        end
      end
    end
  end

  assign bus.value      = value_r;
  assign bus.invalid    = invalid_r;
  assign bus.upd_valid  = upd_valid_r;
  assign bus.upd_idx    = upd_idx_r;
  assign bus.frame_done = frame_done_r;

endmodule

// File: tb/tb_ss_scan_capture.sv
// Scoreboard bench for ss_scan_capture: dwell-level reference model predicts each digit update,
// an independent monitor pops and compares every upd_valid pulse.
module tb_ss_scan_capture;
  import ss_pkg::*;

  localparam int ND = 4;
  localparam int SC = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ss_scan_capture_if #(.NUM_DIGITS(ND)) bus ();

  ss_scan_capture #(
    .NUM_DIGITS    (ND),
    .STABLE_CYCLES (SC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int          idx;
    logic [15:0] val;
    logic [3:0]  inv;
    logic        frame;
  } upd_t;

  upd_t exp_q[$];
  upd_t got;

  int total = 0, bad = 0;
  int cyc = 0, upd_count = 0, frame_count = 0, last_upd_cyc = -1, last_frame_idx = -1;
  logic [6:0] seg_tab [0:9];

  // Reference model state: a run of identical one-hot samples, and whether the dwell was taken.
  bit          m_held;
  logic [3:0]  m_held_en;
  int          m_run;
  logic [6:0]  m_seg;
  logic [3:0]  m_en;
  logic [3:0]  m_mask;
  logic [15:0] m_val;
  logic [3:0]  m_inv;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [4:0] decode_ref(input logic [6:0] s);
    for (int i = 0; i < 10; i++) begin
      if (seg_tab[i] == s) return {1'b0, 4'(i)};
    end
    return {1'b1, CODE_INVALID};
  endfunction

  task automatic model_reset();
    m_held = 1'b0; m_held_en = '0; m_run = 0; m_seg = '0; m_en = '0;
    m_mask = '0; m_val = 16'hFFFF; m_inv = 4'hF;
    exp_q.delete();
  endtask

  task automatic model_sample(input logic [6:0] s, input logic [3:0] e);
    upd_t r;
    logic [4:0] d;
    int idx;
    if (m_held) begin
      // The sample that ends a captured dwell is consumed, never starts a new run.
      if (e != m_held_en) begin
        m_held = 1'b0;
        m_run  = 0;
      end
      return;
    end
    if ($countones(e) != 1) begin
      m_run = 0;
      return;
    end
    if (m_run > 0 && s == m_seg && e == m_en) m_run++;
    else begin
      m_run = 1; m_seg = s; m_en = e;
    end
    if (m_run == SC) begin
      idx = 0;
      for (int i = 0; i < ND; i++) if (e[i]) idx = i;
      d = decode_ref(s);
      m_val[4*idx +: 4] = d[3:0];
      m_inv[idx]        = d[4];
      m_mask            = m_mask | e;
      r.idx   = idx;
      r.val   = m_val;
      r.inv   = m_inv;
      r.frame = (m_mask == 4'hF);
      if (r.frame) m_mask = '0;
      exp_q.push_back(r);
      m_held    = 1'b1;
      m_held_en = e;
      m_run     = 0;
    end
  endtask

  task automatic step(input logic [6:0] s, input logic [3:0] e);
    bus.seg    = s;
    bus.dig_en = e;
    model_sample(s, e);
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.upd_valid) begin
        upd_count++;
        last_upd_cyc = cyc;
        if (bus.frame_done) begin
          frame_count++;
          last_frame_idx = int'(bus.upd_idx);
        end
        if (exp_q.size() == 0) begin
          chk("unexpected_upd", 1, 0);
        end else begin
          got = exp_q.pop_front();
          chk("upd_idx", 32'(bus.upd_idx), 32'(got.idx));
          chk("value", 32'(bus.value), 32'(got.val));
          chk("invalid", 32'(bus.invalid), 32'(got.inv));
          chk("frame_done", 32'(bus.frame_done), 32'(got.frame));
        end
      end else if (bus.frame_done) begin
        chk("stray_frame_done", 1, 0);
      end
    end
  end

  initial begin
    int start, n0, f0, chg;
    logic [3:0] mh [0:4];
    logic [3:0] e;
    logic [6:0] s;
    int r, len;

    seg_tab[0] = SEG_0; seg_tab[1] = SEG_1; seg_tab[2] = SEG_2; seg_tab[3] = SEG_3;
    seg_tab[4] = SEG_4; seg_tab[5] = SEG_5; seg_tab[6] = SEG_6; seg_tab[7] = SEG_7;
    seg_tab[8] = SEG_8; seg_tab[9] = SEG_9;
    mh[0] = 4'b0011; mh[1] = 4'b0101; mh[2] = 4'b1100; mh[3] = 4'b1111; mh[4] = 4'b0110;

    bus.seg    = SEG_BLANK;
    bus.dig_en = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_value", 32'(bus.value), 32'hFFFF);
    chk("rst_invalid", 32'(bus.invalid), 32'hF);
    chk("rst_upd_valid", 32'(bus.upd_valid), 0);
    chk("rst_upd_idx", 32'(bus.upd_idx), 0);
    chk("rst_frame_done", 32'(bus.frame_done), 0);

    // Single held digit: capture on the 5th edge, then silence.
    rst_n = 1'b1;
    start = cyc;
    n0    = upd_count;
    repeat (25) step(SEG_1, 4'b0001);
    #1;
    chk("t1_upd_count", 32'(upd_count - n0), 1);
    chk("t1_latency", 32'(last_upd_cyc - start), 5);
    chk("t1_value0", 32'(bus.value[3:0]), 1);
    chk("t1_invalid0", 32'(bus.invalid[0]), 0);

    // Full scan 2,3,4,5 across digits 0..3; completes the frame.
    repeat (2) step(SEG_BLANK, 4'b0000);
    n0 = upd_count;
    f0 = frame_count;
    for (int d = 0; d < 4; d++) begin
      repeat (8) step(seg_tab[d+2], 4'(1 << d));
    end
    #1;
    chk("t2_value", 32'(bus.value), 32'h5432);
    chk("t2_invalid", 32'(bus.invalid), 0);
    chk("t2_upd_count", 32'(upd_count - n0), 4);
    chk("t2_frame_count", 32'(frame_count - f0), 1);
    chk("t2_frame_idx", 32'(last_frame_idx), 3);

    // Bouncing segments on digit 1, then a stable 8.
    for (int k = 0; k < 10; k++) step(((k / 2) % 2) ? SEG_1 : SEG_7, 4'b0010);
    chg = cyc + 1;
    n0  = upd_count;
    repeat (8) step(SEG_8, 4'b0010);
    #1;
    chk("t3_upd_count", 32'(upd_count - n0), 1);
    chk("t3_latency", 32'(last_upd_cyc - chg), 4);
    chk("t3_value1", 32'(bus.value[7:4]), 8);

    // Blank glyph marks the digit invalid; a later good dwell clears it.
    repeat (2) step(SEG_BLANK, 4'b0000);
    repeat (8) step(SEG_BLANK, 4'b0100);
    #1;
    chk("t4_blank_value2", 32'(bus.value[11:8]), 32'hF);
    chk("t4_blank_inv2", 32'(bus.invalid[2]), 1);
    repeat (2) step(SEG_BLANK, 4'b0000);
    repeat (8) step(SEG_0, 4'b0100);
    #1;
    chk("t4_zero_value2", 32'(bus.value[11:8]), 0);
    chk("t4_zero_inv2", 32'(bus.invalid[2]), 0);

    // Multi-hot and all-zero enables never capture.
    n0 = upd_count;
    repeat (10) step(SEG_3, 4'b0011);
    repeat (10) step(SEG_3, 4'b0000);
    #1;
    chk("t5_no_upd", 32'(upd_count - n0), 0);

    // Reset in the middle of a settle.
    repeat (3) step(SEG_9, 4'b1000);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_value", 32'(bus.value), 32'hFFFF);
    chk("t6_rst_invalid", 32'(bus.invalid), 32'hF);
    chk("t6_rst_upd_valid", 32'(bus.upd_valid), 0);
    chk("t6_sb_empty", 32'(exp_q.size()), 0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    start = cyc;
    n0    = upd_count;
    repeat (10) step(SEG_9, 4'b1000);
    #1;
    chk("t6_upd_count", 32'(upd_count - n0), 1);
    chk("t6_latency", 32'(last_upd_cyc - start), 5);
    chk("t6_value3", 32'(bus.value[15:12]), 9);

    // Random dwells with glitches, blanks, garbage patterns and illegal enables.
    for (int dw = 0; dw < 80; dw++) begin
      r = $urandom_range(0, 9);
      if (r < 7)       e = 4'(1 << $urandom_range(0, 3));
      else if (r == 7) e = 4'b0000;
      else if (r == 8) e = mh[$urandom_range(0, 4)];
      else             e = 4'($urandom);
      r = $urandom_range(0, 11);
      if (r < 10)       s = seg_tab[r];
      else if (r == 10) s = SEG_BLANK;
      else              s = 7'($urandom);
      len = $urandom_range(1, 9);
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 9) == 0) step(7'($urandom), e);
        else                           step(s, e);
      end
    end
    repeat (10) step(SEG_BLANK, 4'b0000);
    #1;
    chk("sb_drain", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ss_scan_capture.md
Name: ss_scan_capture

Overview:
- Receive-side counterpart of the team's 4-bit-to-seven-segment encoder.
- Samples a multiplexed seven-segment bus (segment lines plus one-hot digit enables) and waits for each digit dwell to settle.
- Decodes the segment pattern back to a 4-bit BCD code and stores one register per digit.
- Used for display loopback checking and for reading external meters that have seven-segment outputs.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits and the width of dig_en. Must be at least 1.
- STABLE_CYCLES, 4, number of consecutive identical samples required before a capture. Must be at least 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- seg  input  7  segment lines, active-high; bit6=a, bit5=b, bit4=c, bit3=d, bit2=e, bit1=f, bit0=g.
- dig_en  input  NUM_DIGITS  digit enables, active-high; only a one-hot value is legal for capture.
- value  output  4*NUM_DIGITS  decoded code per digit; digit i occupies bits [4i+3:4i].
- invalid  output  NUM_DIGITS  per digit, 1 = the last capture was not a legal digit pattern.
- upd_valid  output  1  one-cycle pulse when a digit register is written.
- upd_idx  output  clog2(NUM_DIGITS), min 1  index of the digit written; meaningful only while upd_valid is high.
- frame_done  output  1  one-cycle pulse when every digit has been captured since the previous frame_done.

Behaviour:
- Reset (async assert, sync release) sets:
  - value to all 4'hF and invalid to all 1s;
  - upd_valid, upd_idx and frame_done to 0;
  - the capture mask to 0, the counter to 0 and the state to IDLE.
- Input stage: seg and dig_en are registered once (seg_q, en_q) every cycle. All later logic uses only the registered values.
- Decode table (abcdefg → code):
  - 1111110→0, 0110000→1, 1101101→2, 1111001→3, 0110011→4
  - 1011011→5, 1011111→6, 1110000→7, 1111111→8, 1111011→9
  - Any other pattern, including blank 0000000, → code 4'hF with invalid=1.
- FSM states: IDLE, SETTLE, HOLD.
  - IDLE: when en_q is one-hot, latch seg_q/en_q as the reference, set cnt=1, go to SETTLE. If STABLE_CYCLES=1, capture immediately instead.
  - SETTLE, sample equals reference: cnt increments. When cnt reaches STABLE_CYCLES, capture and go to HOLD.
  - SETTLE, sample differs and en_q is one-hot: reload the reference, set cnt=1, stay in SETTLE.
  - SETTLE, en_q not one-hot (zero or multi-hot): go to IDLE with no capture.
  - HOLD: stay while en_q equals the reference enable, so there is one capture per dwell. Any change in en_q goes to IDLE. A seg change with en_q unchanged is ignored.
- Capture:
  - Write the digit register and its invalid bit.
  - upd_valid=1 and upd_idx=index for exactly one cycle.
  - Set the corresponding capture-mask bit.
- Latency: with inputs held from before clock edge 1, seg_q is valid after edge 1 and upd_valid is high after edge 1+STABLE_CYCLES. For STABLE_CYCLES=4, that is the 5th edge.
- frame_done:
  - Pulses in the same cycle as the capture that makes the mask all 1s.
  - The mask clears in that cycle. A capture in the following cycle starts the new mask.
  - Recapturing a digit already set in the mask does not pulse frame_done.
- Reset mid-SETTLE or mid-HOLD discards any partial count. No upd_valid is issued.
- The counter saturates logic-wise at STABLE_CYCLES and never wraps.

Decomposition:
- Package ss_pkg holds:
  - segment constants SEG_0..SEG_9 and SEG_BLANK;
  - CODE_INVALID = 4'hF;
  - the FSM state type.
- The encoder testbench reuses the same constants.
- One sub-module: ss_pattern_decode. It is combinational, takes 7-bit seg and returns the 4-bit code plus an invalid flag, and is instantiated once on seg_q.

Test Plan (all scenarios use NUM_DIGITS=4, STABLE_CYCLES=4):
- Reset, then hold dig_en=0001 and seg=0110000 → upd_valid high after the 5th edge, upd_idx=0, value[3:0]=1, invalid[0]=0. No second pulse while the input is held for 20 cycles.
- Scan digits 0..3 with 1101101, 1111001, 0110011, 1011011, 8 cycles each → value=16'h5432, invalid=0000. frame_done pulses together with the upd_valid for idx 3.
- dig_en=0010 with seg toggling every 2 cycles for 10 cycles, then stable 1111111 → exactly one upd_valid, 5 edges after the last change, value[7:4]=8.
- dig_en=0100, seg=0000000 held → value[11:8]=F, invalid[2]=1. Then a new dwell with 1111110 → value[11:8]=0, invalid[2]=0.
- dig_en=0011 held for 10 cycles → no upd_valid. dig_en=0000 → no upd_valid.
- Assert rst_n=0 after 3 stable cycles of a dwell → outputs return immediately to value=FFFF, invalid=1111, upd_valid=0. After release, a full new 4-cycle settle is required before any capture.
